// File: rtl/arq_tx_scheduler.sv
// ============================================================================
// Module   : arq_tx_scheduler
// Purpose  : ARQ loop sequencer between the mapper FAS strobe and the serial
//            OTN frame transmitter (admission, backoff/retransmit, flush, stats).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module arq_tx_scheduler #(
  parameter int BACKOFF_CYC = 1000,
  parameter int MAX_RETRY   = 3,
  parameter int ACK_TO_CYC  = 2000000,
  parameter int PULSE_CYC   = 4,
  parameter int CNT_W       = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_arq_en,
  input  logic             i_fas_in,
  input  logic [2:0]       i_tr_state,
  input  logic             i_retrans_wait,
  input  logic             i_send_complete,
  output logic             o_fas_out,
  output logic             o_arq_en,
  output logic             o_retrans_en,
  output logic             o_tr_flush,
  output logic             o_busy,
  output logic             o_frame_ok,
  output logic             o_frame_drop,
  output logic             o_fas_blocked,
  output logic             o_ack_timeout,
  output logic [2:0]       o_retry_cnt,
  output logic [CNT_W-1:0] o_ok_cnt,
  output logic [CNT_W-1:0] o_drop_cnt,
  output logic [CNT_W-1:0] o_retx_cnt
);

  localparam int c_PH_MAX = (BACKOFF_CYC > PULSE_CYC) ? BACKOFF_CYC : PULSE_CYC;
  localparam int c_PH_W   = $clog2(c_PH_MAX + 1);
  localparam int c_ACK_W  = $clog2(ACK_TO_CYC + 1);

  localparam logic [2:0] c_TR_IDLE = 3'b000;
  localparam logic [2:0] c_TR_ACK  = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SEND    = 3'd1,
    S_BACKOFF = 3'd2,
    S_RETRANS = 3'd3,
    S_FLUSH   = 3'd4
  } state_t;

  state_t              r_state;
  logic [c_PH_W-1:0]   r_phase;
  logic [c_ACK_W-1:0]  r_ack_cnt;
  logic                r_left_idle;
  logic                r_sc_d;
  logic                r_fas_out, r_arq_en, r_retrans_en, r_tr_flush, r_busy;
  logic                r_frame_ok, r_frame_drop, r_fas_blocked, r_ack_timeout;
  logic [2:0]          r_retry_cnt;
  logic [CNT_W-1:0]    r_ok_cnt, r_drop_cnt, r_retx_cnt;

  logic w_sc_edge;
  logic w_tr_idle;
  logic w_ack_expire;
  logic w_pulse_last;

  assign w_sc_edge    = i_send_complete & ~r_sc_d;
  assign w_tr_idle    = (i_tr_state == c_TR_IDLE);
  // Timer saturates at its terminal value so an expiry masked by a
  // higher-priority event is still seen on the following cycle.
  assign w_ack_expire = (i_tr_state == c_TR_ACK) &&
                        (r_ack_cnt >= c_ACK_W'(ACK_TO_CYC - 1));
  assign w_pulse_last = (r_phase == c_PH_W'(PULSE_CYC - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_phase       <= '0;
      r_ack_cnt     <= '0;
      r_left_idle   <= 1'b0;
      r_sc_d        <= 1'b0;
      r_fas_out     <= 1'b0;
      r_arq_en      <= 1'b0;
      r_retrans_en  <= 1'b0;
      r_tr_flush    <= 1'b0;
      r_busy        <= 1'b0;
      r_frame_ok    <= 1'b0;
      r_frame_drop  <= 1'b0;
      r_fas_blocked <= 1'b0;
      r_ack_timeout <= 1'b0;
      r_retry_cnt   <= '0;
      r_ok_cnt      <= '0;
      r_drop_cnt    <= '0;
      r_retx_cnt    <= '0;
    end else begin
      r_sc_d        <= i_send_complete;
      r_fas_out     <= 1'b0;
      r_frame_ok    <= 1'b0;
      r_frame_drop  <= 1'b0;
      r_retrans_en  <= 1'b0;
      r_tr_flush    <= 1'b0;
      r_fas_blocked <= i_fas_in && ((r_state != S_IDLE) || !w_tr_idle);

      case (r_state)
        S_IDLE: begin
          if (i_fas_in && w_tr_idle) begin
            r_fas_out   <= 1'b1;
            r_arq_en    <= i_arq_en;
            r_retry_cnt <= '0;
            r_left_idle <= 1'b0;
            r_ack_cnt   <= '0;
            r_busy      <= 1'b1;
            r_state     <= S_SEND;
          end
        end

        S_SEND: begin
          if (!w_tr_idle) r_left_idle <= 1'b1;
          if (i_tr_state != c_TR_ACK) r_ack_cnt <= '0;
          else if (!w_ack_expire)     r_ack_cnt <= r_ack_cnt + 1'b1;

          if (w_sc_edge) begin
            r_frame_ok <= 1'b1;
            r_ok_cnt   <= (&r_ok_cnt) ? r_ok_cnt : r_ok_cnt + 1'b1;
          end else if (i_retrans_wait) begin
            r_phase   <= '0;
            r_ack_cnt <= '0;
            r_state   <= (r_retry_cnt < 3'(MAX_RETRY)) ? S_BACKOFF : S_FLUSH;
          end else if (r_left_idle && w_tr_idle) begin
            // Without ARQ there is no ACK, so a return to idle is the delivery.
            if (!r_arq_en) begin
              r_frame_ok <= 1'b1;
              r_ok_cnt   <= (&r_ok_cnt) ? r_ok_cnt : r_ok_cnt + 1'b1;
            end
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (w_ack_expire) begin
            r_ack_timeout <= 1'b1;
            r_phase       <= '0;
            r_state       <= S_FLUSH;
          end
        end

        S_BACKOFF: begin
          if (r_phase == c_PH_W'(BACKOFF_CYC - 1)) begin
            r_phase <= '0;
            r_state <= S_RETRANS;
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end

        S_RETRANS: begin
          r_retrans_en <= 1'b1;
          if (r_phase == '0) begin
            r_retry_cnt <= r_retry_cnt + 1'b1;
            r_retx_cnt  <= (&r_retx_cnt) ? r_retx_cnt : r_retx_cnt + 1'b1;
          end
          if (w_pulse_last) begin
            r_phase <= '0;
            r_state <= S_SEND;
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end

        S_FLUSH: begin
          r_tr_flush <= 1'b1;
          if (r_phase == '0) begin
            r_frame_drop <= 1'b1;
            r_drop_cnt   <= (&r_drop_cnt) ? r_drop_cnt : r_drop_cnt + 1'b1;
          end
          if (w_pulse_last) begin
            r_phase <= '0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_fas_out     = r_fas_out;
  assign o_arq_en      = r_arq_en;
  assign o_retrans_en  = r_retrans_en;
  assign o_tr_flush    = r_tr_flush;
  assign o_busy        = r_busy;
  assign o_frame_ok    = r_frame_ok;
  assign o_frame_drop  = r_frame_drop;
  assign o_fas_blocked = r_fas_blocked;
  assign o_ack_timeout = r_ack_timeout;
  assign o_retry_cnt   = r_retry_cnt;
  assign o_ok_cnt      = r_ok_cnt;
  assign o_drop_cnt    = r_drop_cnt;
  assign o_retx_cnt    = r_retx_cnt;

endmodule

`default_nettype wire

// File: tb/tb_arq_tx_scheduler.sv
// ============================================================================
// Module   : tb_arq_tx_scheduler
// Purpose  : Self-checking bench for arq_tx_scheduler with a transaction-level
//            reference model (frame outcomes -> expected counters and pulses).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_arq_tx_scheduler;

  localparam int B     = 12;
  localparam int MAXR  = 3;
  localparam int ACKTO = 40;
  localparam int P     = 4;
  localparam int CW    = 4;
  localparam int MAXC  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          arq_en = 1'b0, fas_in = 1'b0, retrans_wait = 1'b0, send_complete = 1'b0;
  logic [2:0]    tr_state = 3'b000;
  logic          fas_out, arq_out, retrans_en, tr_flush, busy, frame_ok, frame_drop, fas_blocked, ack_timeout;
  logic [2:0]    retry_cnt;
  logic [CW-1:0] ok_cnt, drop_cnt, retx_cnt;

  arq_tx_scheduler #(.BACKOFF_CYC(B), .MAX_RETRY(MAXR), .ACK_TO_CYC(ACKTO), .PULSE_CYC(P), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rst(rst), .i_arq_en(arq_en), .i_fas_in(fas_in), .i_tr_state(tr_state),
    .i_retrans_wait(retrans_wait), .i_send_complete(send_complete),
    .o_fas_out(fas_out), .o_arq_en(arq_out), .o_retrans_en(retrans_en), .o_tr_flush(tr_flush),
    .o_busy(busy), .o_frame_ok(frame_ok), .o_frame_drop(frame_drop), .o_fas_blocked(fas_blocked),
    .o_ack_timeout(ack_timeout), .o_retry_cnt(retry_cnt), .o_ok_cnt(ok_cnt),
    .o_drop_cnt(drop_cnt), .o_retx_cnt(retx_cnt)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  // Reference model: raw event totals since last reset; counters are their saturated view.
  int raw_ok = 0, raw_drop = 0, raw_retx = 0, raw_adm = 0, raw_blk = 0;
  bit exp_to = 0;
  // Observed pulse totals, sampled just after each active edge.
  int n_fas = 0, n_ok = 0, n_drop = 0, n_blk = 0, n_rise = 0, n_excl = 0;
  bit prev_rt = 0;

  always @(posedge clk) begin
    #1;
    if (retrans_en && tr_flush) n_excl++;
    if (rst) begin
      n_fas = 0; n_ok = 0; n_drop = 0; n_blk = 0; n_rise = 0; prev_rt = 0;
    end else begin
      if (fas_out) n_fas++;
      if (frame_ok) n_ok++;
      if (frame_drop) n_drop++;
      if (fas_blocked) n_blk++;
      if (retrans_en && !prev_rt) n_rise++;
      prev_rt = retrans_en;
    end
  end

  function automatic int sat(int v);
    return (v > MAXC) ? MAXC : v;
  endfunction

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic admit(bit arq);
    fas_in = 1'b1; arq_en = arq;
    cyc(1);
    fas_in = 1'b0;
    raw_adm++;
  endtask

  task automatic model_reset();
    raw_ok = 0; raw_drop = 0; raw_retx = 0; raw_adm = 0; raw_blk = 0; exp_to = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cyc(3); rst = 1'b0; model_reset();
    vectors++;
    if ({fas_out, arq_out, retrans_en, tr_flush, busy, frame_ok, frame_drop, fas_blocked, ack_timeout,
         retry_cnt, ok_cnt, drop_cnt, retx_cnt} !== 24'd0) begin
      miscompares++; $display("FAIL reset_outputs: got ok=%0d drop=%0d retx=%0d busy=%0d want all 0", ok_cnt, drop_cnt, retx_cnt, busy);
    end
  endtask

  task automatic test_arq_off();
    admit(1'b0);
    vectors++; if (fas_out !== 1'b1 || arq_out !== 1'b0) begin miscompares++; $display("FAIL arq_off_admit: fas_out=%0d arq=%0d want 1/0", fas_out, arq_out); end
    tr_state = 3'b001; cyc(100); tr_state = 3'b000; cyc(1);
    raw_ok++;
    vectors++; if (frame_ok !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL arq_off_done: ok=%0d busy=%0d want 1/0", frame_ok, busy); end
    cyc(2);
    vectors++; if (ok_cnt !== CW'(1) || n_ok !== 1 || n_fas !== 1 || n_rise !== 0) begin
      miscompares++; $display("FAIL arq_off_stats: ok_cnt=%0d ok_pulses=%0d fas=%0d retx=%0d want 1/1/1/0", ok_cnt, n_ok, n_fas, n_rise);
    end
  endtask

  task automatic test_one_bad_ack();
    int early, width;
    admit(1'b1);
    tr_state = 3'b001; cyc(5); tr_state = 3'b010; cyc(3);
    retrans_wait = 1'b1; cyc(1); retrans_wait = 1'b0; tr_state = 3'b110;
    early = 0;
    repeat (B) begin cyc(1); if (retrans_en) early++; end
    vectors++; if (early !== 0) begin miscompares++; $display("FAIL backoff_quiet: early_high=%0d want 0", early); end
    cyc(1);
    vectors++; if (retrans_en !== 1'b1) begin miscompares++; $display("FAIL retrans_rise: got %0d want 1", retrans_en); end
    width = 1;
    repeat (P + 2) begin cyc(1); if (retrans_en) width++; end
    raw_retx++;
    vectors++; if (width !== P) begin miscompares++; $display("FAIL retrans_width: got %0d want %0d", width, P); end
    tr_state = 3'b010; cyc(2); tr_state = 3'b110; send_complete = 1'b1; cyc(1);
    raw_ok++;
    vectors++; if (frame_ok !== 1'b1) begin miscompares++; $display("FAIL good_ack_ok: got %0d want 1", frame_ok); end
    cyc(40); send_complete = 1'b0; tr_state = 3'b000; cyc(2);
    vectors++; if (busy !== 1'b0 || ok_cnt !== CW'(2) || retx_cnt !== CW'(1) || retry_cnt !== 3'd1 || n_ok !== raw_ok) begin
      miscompares++; $display("FAIL one_bad_stats: busy=%0d ok=%0d retx=%0d retry=%0d pulses=%0d want 0/2/1/1/%0d", busy, ok_cnt, retx_cnt, retry_cnt, n_ok, raw_ok);
    end
  endtask

  task automatic test_retry_exhaust();
    int r0, width;
    r0 = n_rise;
    admit(1'b1);
    tr_state = 3'b001; cyc(3);
    for (int i = 0; i <= MAXR; i++) begin
      tr_state = 3'b010; cyc(2); retrans_wait = 1'b1; cyc(1); retrans_wait = 1'b0; tr_state = 3'b110;
      if (i < MAXR) begin cyc(B + P + 2); raw_retx++; end
    end
    cyc(1);
    raw_drop++;
    vectors++; if (tr_flush !== 1'b1 || frame_drop !== 1'b1) begin miscompares++; $display("FAIL flush_entry: flush=%0d drop=%0d want 1/1", tr_flush, frame_drop); end
    width = 1;
    repeat (P + 2) begin cyc(1); if (tr_flush) width++; end
    tr_state = 3'b000; cyc(1);
    vectors++; if (width !== P) begin miscompares++; $display("FAIL flush_width: got %0d want %0d", width, P); end
    vectors++; if (n_rise - r0 !== MAXR || drop_cnt !== CW'(1) || busy !== 1'b0 || retry_cnt !== 3'(MAXR)) begin
      miscompares++; $display("FAIL exhaust_stats: rises=%0d drop=%0d busy=%0d retry=%0d want %0d/1/0/%0d", n_rise - r0, drop_cnt, busy, retry_cnt, MAXR, MAXR);
    end
  endtask

  task automatic test_ack_timeout();
    vectors++; if (ack_timeout !== 1'b0) begin miscompares++; $display("FAIL timeout_pre: got %0d want 0", ack_timeout); end
    admit(1'b1);
    tr_state = 3'b010; cyc(ACKTO - 1);
    vectors++; if (ack_timeout !== 1'b0) begin miscompares++; $display("FAIL timeout_early: got %0d want 0", ack_timeout); end
    cyc(1);
    exp_to = 1;
    vectors++; if (ack_timeout !== 1'b1) begin miscompares++; $display("FAIL timeout_set: got %0d want 1", ack_timeout); end
    cyc(1);
    raw_drop++;
    vectors++; if (frame_drop !== 1'b1 || tr_flush !== 1'b1) begin miscompares++; $display("FAIL timeout_drop: drop=%0d flush=%0d want 1/1", frame_drop, tr_flush); end
    tr_state = 3'b000; cyc(P + 2);
    vectors++; if (busy !== 1'b0 || ack_timeout !== 1'b1 || drop_cnt !== CW'(sat(raw_drop))) begin
      miscompares++; $display("FAIL timeout_after: busy=%0d sticky=%0d drop=%0d want 0/1/%0d", busy, ack_timeout, drop_cnt, sat(raw_drop));
    end
    admit(1'b0);
    vectors++; if (fas_out !== 1'b1) begin miscompares++; $display("FAIL timeout_readmit: got %0d want 1", fas_out); end
    tr_state = 3'b001; cyc(3); tr_state = 3'b000; cyc(2); raw_ok++;
  endtask

  task automatic test_fas_gating();
    int f0, b0, arq_bad;
    f0 = n_fas; b0 = n_blk; arq_bad = 0;
    admit(1'b1);
    tr_state = 3'b001; cyc(2);
    arq_en = 1'b0; fas_in = 1'b1; cyc(1); fas_in = 1'b0;
    vectors++; if (fas_blocked !== 1'b1 || fas_out !== 1'b0) begin miscompares++; $display("FAIL block_send: blk=%0d fas_out=%0d want 1/0", fas_blocked, fas_out); end
    tr_state = 3'b010; cyc(2); retrans_wait = 1'b1; cyc(1); retrans_wait = 1'b0; tr_state = 3'b110;
    cyc(2); fas_in = 1'b1; arq_en = 1'b1; cyc(1); fas_in = 1'b0; arq_en = 1'b0;
    vectors++; if (fas_blocked !== 1'b1 || fas_out !== 1'b0) begin miscompares++; $display("FAIL block_backoff: blk=%0d fas_out=%0d want 1/0", fas_blocked, fas_out); end
    repeat (B + P) begin cyc(1); if (arq_out !== 1'b1) arq_bad++; end
    raw_retx++; raw_blk += 2;
    tr_state = 3'b110; send_complete = 1'b1; cyc(5); send_complete = 1'b0; tr_state = 3'b000; cyc(2); raw_ok++;
    vectors++; if (arq_bad !== 0) begin miscompares++; $display("FAIL arq_latched: changed_cycles=%0d want 0", arq_bad); end
    vectors++; if (n_fas - f0 !== 1 || n_blk - b0 !== 2) begin miscompares++; $display("FAIL gating_counts: fas=%0d blk=%0d want 1/2", n_fas - f0, n_blk - b0); end
  endtask

  task automatic test_random();
    int nbad, exp_retry;
    bit arq;
    for (int f = 0; f < 30; f++) begin
      if ($urandom_range(0, 3) == 0) begin
        tr_state = 3'b001; fas_in = 1'b1; cyc(1); fas_in = 1'b0; tr_state = 3'b000; cyc(1); raw_blk++;
      end
      arq = 1'($urandom_range(0, 1));
      admit(arq);
      vectors++; if (arq_out !== arq) begin miscompares++; $display("FAIL rnd_arq f%0d: got %0d want %0d", f, arq_out, arq); end
      tr_state = 3'b001; cyc($urandom_range(1, 8));
      if ($urandom_range(0, 2) == 0) begin fas_in = 1'b1; cyc(1); fas_in = 1'b0; raw_blk++; end
      exp_retry = 0;
      if (!arq) begin
        tr_state = 3'b000; cyc(2); raw_ok++;
      end else begin
        nbad = $urandom_range(0, MAXR + 1);
        exp_retry = (nbad > MAXR) ? MAXR : nbad;
        for (int i = 0; i < nbad; i++) begin
          tr_state = 3'b010; cyc($urandom_range(1, 10));
          retrans_wait = 1'b1; cyc(1); retrans_wait = 1'b0; tr_state = 3'b110;
          if (i < MAXR) begin cyc(B + P + 2); raw_retx++; end
          else begin cyc(P + 2); tr_state = 3'b000; cyc(2); raw_drop++; end
        end
        if (nbad <= MAXR) begin
          if ($urandom_range(0, 4) == 0) begin
            tr_state = 3'b010; cyc(ACKTO + P + 2); tr_state = 3'b000; cyc(2); raw_drop++; exp_to = 1;
          end else begin
            tr_state = 3'b010; cyc($urandom_range(1, 10)); tr_state = 3'b110;
            send_complete = 1'b1; cyc($urandom_range(2, 41)); send_complete = 1'b0;
            tr_state = 3'b000; cyc(2); raw_ok++;
          end
        end
      end
      vectors++; if (ok_cnt !== CW'(sat(raw_ok)) || drop_cnt !== CW'(sat(raw_drop)) || retx_cnt !== CW'(sat(raw_retx))) begin
        miscompares++; $display("FAIL rnd_counters f%0d: ok=%0d drop=%0d retx=%0d want %0d/%0d/%0d", f, ok_cnt, drop_cnt, retx_cnt, sat(raw_ok), sat(raw_drop), sat(raw_retx));
      end
      vectors++; if (retry_cnt !== 3'(exp_retry) || busy !== 1'b0 || ack_timeout !== exp_to) begin
        miscompares++; $display("FAIL rnd_state f%0d: retry=%0d busy=%0d to=%0d want %0d/0/%0d", f, retry_cnt, busy, ack_timeout, exp_retry, exp_to);
      end
      vectors++; if (n_ok !== raw_ok || n_drop !== raw_drop || n_fas !== raw_adm || n_blk !== raw_blk || n_rise !== raw_retx) begin
        miscompares++; $display("FAIL rnd_pulses f%0d: ok=%0d drop=%0d fas=%0d blk=%0d rise=%0d want %0d/%0d/%0d/%0d/%0d", f, n_ok, n_drop, n_fas, n_blk, n_rise, raw_ok, raw_drop, raw_adm, raw_blk, raw_retx);
      end
    end
  endtask

  task automatic test_saturation();
    repeat (MAXC + 2) begin
      admit(1'b0); tr_state = 3'b001; cyc(2); tr_state = 3'b000; cyc(2); raw_ok++;
    end
    vectors++; if (ok_cnt !== CW'(MAXC) || n_ok !== raw_ok) begin
      miscompares++; $display("FAIL ok_saturate: got %0d pulses=%0d want %0d/%0d", ok_cnt, n_ok, MAXC, raw_ok);
    end
  endtask

  task automatic test_reset_mid();
    admit(1'b1);
    tr_state = 3'b001; cyc(2); tr_state = 3'b010; cyc(1);
    retrans_wait = 1'b1; cyc(1); retrans_wait = 1'b0; tr_state = 3'b110;
    cyc(B + 1);
    vectors++; if (retrans_en !== 1'b1) begin miscompares++; $display("FAIL mid_in_retrans: got %0d want 1", retrans_en); end
    rst = 1'b1; cyc(1);
    vectors++; if ({fas_out, arq_out, retrans_en, tr_flush, busy, frame_ok, frame_drop, fas_blocked, ack_timeout,
                    retry_cnt, ok_cnt, drop_cnt, retx_cnt} !== 24'd0) begin
      miscompares++; $display("FAIL mid_reset_outputs: rt=%0d drop=%0d ok=%0d retry=%0d want all 0", retrans_en, frame_drop, ok_cnt, retry_cnt);
    end
    rst = 1'b0; tr_state = 3'b000; model_reset(); cyc(3);
    vectors++; if (n_drop !== 0 || frame_drop !== 1'b0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL mid_no_drop: drops=%0d busy=%0d want 0/0", n_drop, busy);
    end
    admit(1'b0);
    vectors++; if (fas_out !== 1'b1) begin miscompares++; $display("FAIL mid_readmit: got %0d want 1", fas_out); end
    tr_state = 3'b001; cyc(2); tr_state = 3'b000; cyc(2);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_arq_off();
    test_one_bad_ack();
    test_retry_exhaust();
    test_ack_timeout();
    test_fas_gating();
    test_random();
    test_saturation();
    test_reset_mid();
    vectors++;
    if (n_excl !== 0) begin miscompares++; $display("FAIL retrans_flush_overlap: cycles=%0d want 0", n_excl); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
